// File: rtl/binary_to_bcd_if.sv
// Handshake and result bundle for the binary-to-BCD converter.
// The master drives the operands and start; the slave returns the
// registered BCD result together with its status flags.
interface binary_to_bcd_if;
  logic       start;
  logic [7:0] binary_in;
  logic       sign_in;
  logic       overflow_in;
  logic [9:0] BCD_digit;
  logic       sign;
  logic       overflow;
  logic       busy;
  logic       done;

  modport master (
    output start, binary_in, sign_in, overflow_in,
    input  BCD_digit, sign, overflow, busy, done
  );

  modport slave (
    input  start, binary_in, sign_in, overflow_in,
    output BCD_digit, sign, overflow, busy, done
  );
endinterface

// File: rtl/binary_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// One bit is processed per clock: a conversion takes 8 shift cycles plus
// a one-cycle DONE state, and the result registers only change on the
// final shift edge so intermediate scratch values are never visible.
module binary_to_bcd (
  input  logic           clk,
  input  logic           rst_n,
  binary_to_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  count_reg;
  logic [9:0]  scratch_reg;
  logic [7:0]  shift_reg;
  logic        sign_cap_reg;
  logic        overflow_cap_reg;

  logic [9:0]  digit_reg;
  logic        sign_reg;
  logic        overflow_reg;

  logic        busy_next;
  logic        done_next;

  logic [9:0]  adjusted;
  logic [17:0] step_full;
  logic [9:0]  scratch_step;
  logic [7:0]  shift_step;
  logic        last_step;

  // Ones and tens nibbles get +3 when >= 5 so the following shift carries
  // correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adjust
      assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                 ? scratch_reg[gi*4 +: 4] + 4'd3
                                 : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // Hundreds never exceeds 2 for 8-bit inputs, so it is never adjusted.
  assign adjusted[9:8] = scratch_reg[9:8];

  // Shift the joined {BCD, binary} word left by one; the MSB falls off.
  assign step_full    = {adjusted, shift_reg} << 1;
  assign scratch_step = step_full[17:8];
  assign shift_step   = step_full[7:0];
  assign last_step    = (count_reg == 4'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy_next = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_next  = 1'b1;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, double-dabble stepping and result register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg        <= 4'd0;
      scratch_reg      <= 10'd0;
      shift_reg        <= 8'd0;
      sign_cap_reg     <= 1'b0;
      overflow_cap_reg <= 1'b0;
      digit_reg        <= 10'd0;
      sign_reg         <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            shift_reg        <= bus.binary_in;
            sign_cap_reg     <= bus.sign_in;
            overflow_cap_reg <= bus.overflow_in;
            scratch_reg      <= 10'd0;
            count_reg        <= 4'd8;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_step;
          shift_reg   <= shift_step;
          count_reg   <= count_reg - 4'd1;
          if (last_step) begin
            digit_reg    <= scratch_step;
            sign_reg     <= sign_cap_reg;
            overflow_reg <= overflow_cap_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.BCD_digit = digit_reg;
  assign bus.sign      = sign_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.busy      = busy_next;
  assign bus.done      = done_next;

endmodule

// File: doc/binary_to_bcd.md
BINARY_TO_BCD -- requirements
Module: binary_to_bcd

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a conversion; sampled on the rising edge of clk.
REQ-005 binary_in  input  8  unsigned magnitude to convert (0..255).
REQ-006 sign_in  input  1  sign flag, captured with binary_in.
REQ-007 overflow_in  input  1  overflow flag, captured with binary_in.
REQ-008 BCD_digit  output  10  registered result: [9:8] hundreds (0..2), [7:4] tens, [3:0] ones.
REQ-009 sign  output  1  registered sign flag belonging to BCD_digit.
REQ-010 overflow  output  1  registered overflow flag belonging to BCD_digit.
REQ-011 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-012 done  output  1  single-cycle pulse marking the cycle in which a new result first appears on the outputs.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE, start=1 at edge E0:
- capture binary_in, sign_in and overflow_in into internal registers;
- clear the 10-bit BCD scratch register;
- load the iteration counter with 8;
- go to SHIFT.
REQ-015 IDLE, start=0: remain in IDLE; all outputs hold.
REQ-016 Each SHIFT edge SHALL perform one double-dabble step:
- add 3 to every BCD nibble whose value is >=5;
- then shift {BCD scratch, binary shift register} left by one bit;
- decrement the counter.
REQ-017 The adjust SHALL apply to the ones and tens nibbles; the hundreds field is 2 bits wide and needs no adjust for inputs <=255.
REQ-018 Eight SHIFT steps occur on edges E1..E8.
REQ-019 At edge E8:
- go to DONE;
- load BCD_digit, sign and overflow from the final scratch value and the captured flags in the same edge.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE at edge E9.
REQ-021 done = 1 only while in DONE, so it is high for the single cycle between E8 and E9.
REQ-022 busy = 1 for the cycles between E0 and E9 (SHIFT and DONE states).
REQ-023 Latency: the result is visible on the outputs 8 clock edges after the accepting edge; throughput is one conversion per 10 cycles.
REQ-024 start while in SHIFT or DONE SHALL be ignored; it is neither queued nor does it alter the captured operands.
REQ-025 start=1 held continuously SHALL start a new conversion on each entry into IDLE, i.e. at E10, E20, ...
REQ-026 Between completions, BCD_digit, sign and overflow SHALL hold the previous result.
REQ-027 The outputs SHALL never show intermediate scratch values.
REQ-028 overflow_in=1 SHALL NOT suppress conversion; the magnitude is converted and the flag is passed through.
REQ-029 Every output nibble SHALL be a legal BCD value (<=9) for all 256 inputs.

Reset
REQ-030 rst_n=0 SHALL immediately force the following, independent of clk:
- state IDLE;
- BCD_digit=0, sign=0, overflow=0, busy=0, done=0;
- counter, scratch and captured registers = 0.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; no partial result is ever output.
REQ-032 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-033 binary_in=255, sign_in=0, overflow_in=0, pulse start -> 8 edges later done=1 for 1 cycle, BCD_digit=10'b10_0101_0101 (2,5,5).
REQ-034 binary_in=0, then binary_in=99 with sign_in=1 -> BCD_digit=0, then BCD_digit=10'b00_1001_1001 with sign=1.
REQ-035 start pulsed again 3 cycles after acceptance with a different binary_in -> ignored; result matches the first operand; exactly one done pulse.
REQ-036 rst_n pulled low at cycle 4 of a conversion of 200 -> all outputs 0 at once, no done; a new start of 200 then yields 10'b10_0000_0000.
REQ-037 start held high for 40 cycles, binary_in=137, overflow_in=1 -> done pulses every 10 cycles; BCD_digit=10'b01_0011_0111 with overflow=1.
REQ-038 Exhaustive sweep 0..255 -> every result equals the reference decimal decomposition and all nibbles are <=9.
